// File: rtl/controle_engarrafamento.sv
// rtl/controle_engarrafamento.sv - bottling line sequencer: conveyor, filler, capper, dozen/batch control
//
// Runs one bottle at a time through ADVANCE -> FILL -> SEAL -> RELEASE -> COUNT -> CHECK.
// Counts bottles 0..11, pulses the external dozen counter once per dozen and halts the
// line when that counter reads DOZEN_LIMIT.
//
// Optional feature macro: FILL_TIMEOUT_EN
//   defined     : fill timer, FAULT state and ALARM are built
//   not defined : FILL waits for FULL indefinitely, ALARM tied to 0, FILL_TIMEOUT unused
//
// Parameters:
//   FILL_TIMEOUT  max cycles VALVE stays open before a fault (1..255)
//   SEAL_CYCLES   cycles SEAL is held per bottle (1..15)
//   DOZEN_LIMIT   dozen-counter value that ends a batch (1..10)
//
// Ports:
//   CLOCK        in   system clock, rising edge
//   RESET        in   synchronous, active-high reset
//   START        in   start / resume / acknowledge (level)
//   STOP         in   halt request (level)
//   SENSOR       in   bottle present under filler
//   FULL         in   bottle full
//   DOZEN_COUNT  in   current value of the external dozen counter
//   CONVEYOR     out  conveyor motor on
//   VALVE        out  fill valve open
//   SEAL         out  capper active
//   DOZEN_PULSE  out  one-cycle increment to the dozen counter
//   BOTTLES      out  bottles in the current dozen (0..11)
//   BATCH_DONE   out  batch complete, line halted
//   ALARM        out  fill timeout fault

module controle_engarrafamento #(
    parameter int FILL_TIMEOUT = 200,
    parameter int SEAL_CYCLES  = 4,
    parameter int DOZEN_LIMIT  = 10
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       SENSOR,
    input  logic       FULL,
    input  logic [3:0] DOZEN_COUNT,
    output logic       CONVEYOR,
    output logic       VALVE,
    output logic       SEAL,
    output logic       DOZEN_PULSE,
    output logic [3:0] BOTTLES,
    output logic       BATCH_DONE,
    output logic       ALARM
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADVANCE,
        S_FILL,
        S_SEAL,
        S_RELEASE,
        S_COUNT,
        S_CHECK,
        S_BATCH,
        S_CLEAR,
        S_CLEAR_WAIT
`ifdef FILL_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    localparam logic [3:0] SEAL_LAST = 4'(SEAL_CYCLES - 1);
    localparam logic [3:0] LIMIT     = 4'(DOZEN_LIMIT);

    state_t     state;
    state_t     next_state;
    logic [3:0] bottles;
    logic [3:0] seal_cnt;
    logic       stop_latch;

`ifdef FILL_TIMEOUT_EN
    localparam logic [7:0] FILL_LIMIT = 8'(FILL_TIMEOUT);
    logic [7:0] fill_cnt;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (START && !STOP) next_state = S_ADVANCE;
            S_ADVANCE: begin
                if (STOP)        next_state = S_IDLE;
                else if (SENSOR) next_state = S_FILL;
            end
            S_FILL: begin
                // FULL has priority over the timeout when both occur together
                if (FULL) next_state = S_SEAL;
`ifdef FILL_TIMEOUT_EN
                else if (fill_cnt == FILL_LIMIT) next_state = S_FAULT;
`endif
            end
            S_SEAL:    if (seal_cnt == SEAL_LAST) next_state = S_RELEASE;
            S_RELEASE: if (!SENSOR) next_state = S_COUNT;
            S_COUNT:   next_state = S_CHECK;
            S_CHECK: begin
                // DOZEN_COUNT already reflects the pulse issued in COUNT
                if (DOZEN_COUNT == LIMIT) next_state = S_BATCH;
                else if (stop_latch)      next_state = S_IDLE;
                else                      next_state = S_ADVANCE;
            end
            S_BATCH:   if (START) next_state = S_CLEAR;
            // A limit of 10 wraps with a single pulse; smaller limits keep
            // pulsing (with a settle cycle between pulses) until the counter reads 0.
            S_CLEAR:      next_state = (DOZEN_LIMIT == 10) ? S_ADVANCE : S_CLEAR_WAIT;
            S_CLEAR_WAIT: next_state = (DOZEN_COUNT == 4'd0) ? S_ADVANCE : S_CLEAR;
`ifdef FILL_TIMEOUT_EN
            S_FAULT:   if (START && !FULL) next_state = S_IDLE;
`endif
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= S_IDLE;
            bottles    <= 4'd0;
            seal_cnt   <= 4'd0;
            stop_latch <= 1'b0;
        end else begin
            state <= next_state;

            if (state == S_COUNT)
                bottles <= (bottles == 4'd11) ? 4'd0 : bottles + 4'd1;

            seal_cnt <= (state == S_SEAL && next_state == S_SEAL) ? seal_cnt + 4'd1 : 4'd0;

            // A stop during the bottle cycle lets the bottle finish and be counted
            if (next_state == S_IDLE)
                stop_latch <= 1'b0;
            else if (STOP && (state == S_FILL || state == S_SEAL || state == S_RELEASE))
                stop_latch <= 1'b1;
        end
    end

`ifdef FILL_TIMEOUT_EN
    always_ff @(posedge CLOCK) begin
        if (RESET)
            fill_cnt <= 8'd0;
        else
            fill_cnt <= (state == S_FILL && next_state == S_FILL) ? fill_cnt + 8'd1 : 8'd0;
    end

    assign ALARM = (state == S_FAULT);
`else
    assign ALARM = 1'b0;
`endif

    assign CONVEYOR    = (state == S_ADVANCE) || (state == S_RELEASE);
    assign VALVE       = (state == S_FILL);
    assign SEAL        = (state == S_SEAL);
    assign DOZEN_PULSE = ((state == S_COUNT) && (bottles == 4'd11)) || (state == S_CLEAR);
    assign BOTTLES     = bottles;
    assign BATCH_DONE  = (state == S_BATCH);

endmodule

// File: tb/tb_controle_engarrafamento.sv
// tb/tb_controle_engarrafamento.sv - randomized self-checking bench for controle_engarrafamento

module tb_controle_engarrafamento;

    localparam int FILL_TIMEOUT = 8;
    localparam int SEAL_CYCLES  = 4;
    localparam int DOZEN_LIMIT  = 10;

    // expected output vector: {CONVEYOR, VALVE, SEAL, DOZEN_PULSE, BATCH_DONE, ALARM}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_CONV = 6'b100000;
    localparam logic [5:0] O_VALV = 6'b010000;
    localparam logic [5:0] O_SEAL = 6'b001000;
    localparam logic [5:0] O_PULS = 6'b000100;
    localparam logic [5:0] O_BATC = 6'b000010;
    localparam logic [5:0] O_ALRM = 6'b000001;

    logic       CLOCK;
    logic       RESET;
    logic       START;
    logic       STOP;
    logic       SENSOR;
    logic       FULL;
    logic [3:0] DOZEN_COUNT;
    logic       CONVEYOR;
    logic       VALVE;
    logic       SEAL;
    logic       DOZEN_PULSE;
    logic [3:0] BOTTLES;
    logic       BATCH_DONE;
    logic       ALARM;

    int n_checks = 0;
    int n_fail   = 0;
    int m_bottles = 0;
    int m_dozen   = 0;

    controle_engarrafamento #(
        .FILL_TIMEOUT (FILL_TIMEOUT),
        .SEAL_CYCLES  (SEAL_CYCLES),
        .DOZEN_LIMIT  (DOZEN_LIMIT)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .START       (START),
        .STOP        (STOP),
        .SENSOR      (SENSOR),
        .FULL        (FULL),
        .DOZEN_COUNT (DOZEN_COUNT),
        .CONVEYOR    (CONVEYOR),
        .VALVE       (VALVE),
        .SEAL        (SEAL),
        .DOZEN_PULSE (DOZEN_PULSE),
        .BOTTLES     (BOTTLES),
        .BATCH_DONE  (BATCH_DONE),
        .ALARM       (ALARM)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // external dozen counter on the line: 0..10, wraps on the pulse after 10
    always_ff @(posedge CLOCK) begin
        if (RESET)
            DOZEN_COUNT <= 4'd0;
        else if (DOZEN_PULSE)
            DOZEN_COUNT <= (DOZEN_COUNT == 4'd10) ? 4'd0 : DOZEN_COUNT + 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare the current cycle's outputs, then present inputs for the edge that ends it.
    task automatic step(input string tag, input logic sen, input logic full,
                        input logic start, input logic stop, input logic rst,
                        input logic [5:0] exp_out);
        check({tag, "_out"}, int'({CONVEYOR, VALVE, SEAL, DOZEN_PULSE, BATCH_DONE, ALARM}), int'(exp_out));
        check({tag, "_bottles"}, int'(BOTTLES), m_bottles);
        check({tag, "_dozen"}, int'(DOZEN_COUNT), m_dozen);
        SENSOR = sen;
        FULL   = full;
        START  = start;
        STOP   = stop;
        RESET  = rst;
        @(negedge CLOCK);
    endtask

    // One bottle from ADVANCE through CHECK. da/df/dr: cycles the plant waits before
    // raising SENSOR, raising FULL and dropping SENSOR respectively.
    task automatic bottle(input int da, input int df, input int dr, input bit stop_in_seal);
        bit pulse;
        for (int i = 0; i <= da; i++) step("advance", (i == da), 1'b0, 1'b0, 1'b0, 1'b0, O_CONV);
        for (int i = 0; i <= df; i++) step("fill", 1'b1, (i == df), 1'b0, 1'b0, 1'b0, O_VALV);
        for (int i = 0; i < SEAL_CYCLES; i++)
            step("seal", 1'b1, 1'b0, 1'b0, stop_in_seal && (i == 0), 1'b0, O_SEAL);
        for (int i = 0; i <= dr; i++) step("release", (i < dr), 1'b0, 1'b0, 1'b0, 1'b0, O_CONV);
        pulse = (m_bottles == 11);
        step("count", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pulse ? O_PULS : O_NONE);
        if (pulse) begin
            m_bottles = 0;
            m_dozen   = (m_dozen == 10) ? 0 : m_dozen + 1;
        end else begin
            m_bottles = m_bottles + 1;
        end
        step("check", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    endtask

    task automatic rand_bottle();
        bottle(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)), 1'b0);
    endtask

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        STOP   = 1'b0;
        SENSOR = 1'b0;
        FULL   = 1'b0;
        repeat (2) @(negedge CLOCK);

        // reset state, then start
        step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("idle_go", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);

        // first dozen with instant sensors: 9 cycles per bottle, one pulse at the 12th
        for (int b = 0; b < 12; b++) bottle(0, 0, 0, 1'b0);

        // rest of the batch with random sensor latencies
        for (int b = 12; b < 120; b++) rand_bottle();

        // batch halted; STOP ignored here, START with STOP still clears
        step("batch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_BATC);
        step("batch_stop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_BATC);
        step("batch_go", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_BATC);
        step("clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_PULS);
        m_dozen = 0;

        // line restarts
        for (int b = 0; b < 5; b++) rand_bottle();

        // STOP during SEAL at BOTTLES=5: bottle completes, then IDLE
        bottle(0, 0, 0, 1'b1);
        step("stopped", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("stopped2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);

        // START and STOP together in IDLE, then STOP in ADVANCE
        step("idle_both", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_NONE);
        step("idle_go_b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);
        step("adv_stop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_CONV);
        step("idle_back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);

        // RESET mid-FILL at BOTTLES=7
        step("idle_go_r", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);
        bottle(0, 0, 0, 1'b0);
        step("adv_r", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_CONV);
        step("fill_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_VALV);
        m_bottles = 0;
        m_dozen   = 0;
        step("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("idle_go_f", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);
        rand_bottle();
        rand_bottle();

`ifdef FILL_TIMEOUT_EN
        // FULL never comes: ALARM FILL_TIMEOUT+1 cycles after FILL entry
        step("adv_t", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_CONV);
        for (int i = 0; i <= FILL_TIMEOUT; i++) step("fill_to", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_VALV);
        step("fault", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_ALRM);
        step("fault_full", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_ALRM);
        step("fault_ack", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_ALRM);
        step("idle_f", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("idle_go_t", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);
        // FULL in the same cycle the timer hits its limit: SEAL wins
        bottle(0, FILL_TIMEOUT, 0, 1'b0);
`else
        // no timer: FILL waits well past FILL_TIMEOUT
        bottle(0, 3 * FILL_TIMEOUT, 0, 1'b0);
`endif
        step("final", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_CONV);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_engarrafamento.md
# controle_engarrafamento

Sequencer for the wine bottling line. Drives conveyor, fill valve and capper through one bottle cycle at a time. Counts bottles 0–11 internally and issues one `ENABLE` pulse per completed dozen to the dozen counter (0–10, wraps to 0 on the pulse after 10). Reads that counter back to stop the line when a batch of `DOZEN_LIMIT` dozens is complete.

## Interface
Parameters:
- `FILL_TIMEOUT`, 200: max cycles `VALVE` stays open before fault; range 1–255.
- `SEAL_CYCLES`, 4: cycles `SEAL` is held per bottle; range 1–15.
- `DOZEN_LIMIT`, 10: dozen-counter value that ends a batch; range 1–10.

Ports:
- `CLOCK` in 1: system clock, rising edge.
- `RESET` in 1: **synchronous, active-high** reset.
- `START` in 1: level; starts, resumes or acknowledges.
- `STOP` in 1: level; requests a halt.
- `SENSOR` in 1: bottle present under filler.
- `FULL` in 1: level sensor, bottle full.
- `DOZEN_COUNT` in 4: current value of the dozen counter.
- `CONVEYOR` out 1: conveyor motor on.
- `VALVE` out 1: fill valve open.
- `SEAL` out 1: capper active.
- `DOZEN_PULSE` out 1: one-cycle increment to the dozen counter `ENABLE`.
- `BOTTLES` out 4: bottles in the current dozen, 0–11.
- `BATCH_DONE` out 1: batch complete, line halted.
- `ALARM` out 1: fill timeout fault.

## Operation
- Moore FSM. All outputs decode from registered state and counters. No combinational input-to-output paths.
- States:
  - IDLE: outputs 0. `START` and not `STOP` → ADVANCE.
  - ADVANCE: `CONVEYOR`=1. `STOP` → IDLE (takes priority). Otherwise `SENSOR` → FILL.
  - FILL: `VALVE`=1. Fill timer increments each cycle. `FULL` → SEAL, timer cleared. Timer reaching `FILL_TIMEOUT` → FAULT.
  - SEAL: `SEAL`=1 for exactly `SEAL_CYCLES` cycles, then → RELEASE.
  - RELEASE: `CONVEYOR`=1 until `SENSOR`=0, then → COUNT.
  - COUNT: one cycle.
    - `BOTTLES` 0–10 → +1, next CHECK.
    - `BOTTLES`=11 → 0 and `DOZEN_PULSE`=1 for this cycle, next CHECK.
  - CHECK: one cycle.
    - `DOZEN_COUNT`==`DOZEN_LIMIT` → BATCH.
    - Else stop latch set → IDLE.
    - Else → ADVANCE.
  - BATCH: `BATCH_DONE`=1. `START` → CLEAR.
  - CLEAR: one cycle with `DOZEN_PULSE`=1, so the counter wraps 10→0. Then → ADVANCE.
    - When `DOZEN_LIMIT`<10, CLEAR instead pulses until `DOZEN_COUNT` reads 0: each pulse is followed by one wait cycle.
  - FAULT: `ALARM`=1, valve closed. `START` with `FULL`=0 → IDLE. The bottle is not counted.
- Stop latch: set by `STOP` in FILL, SEAL or RELEASE. The cycle in progress completes and counts, then the FSM returns to IDLE. The latch clears on entry to IDLE.
- `BOTTLES` holds its value across IDLE, BATCH and FAULT. Only `RESET` or the 11→0 wrap clears it.
- `START` and `STOP` both high: `STOP` wins everywhere except BATCH and FAULT, which ignore `STOP`.

## Timing
- Reset values: state IDLE; `BOTTLES`=0; fill timer, seal timer and stop latch 0; all outputs 0.
- Each transition takes effect at the first `CLOCK` edge where its condition is sampled true. The output changes in the following cycle.
- `RESET` sampled high aborts any state, including FILL with `VALVE` open. `VALVE` is 0 the cycle after.
- `DOZEN_PULSE` is never high on two consecutive cycles.
- CHECK samples `DOZEN_COUNT` one cycle after the `DOZEN_PULSE` edge, so the counter's update is visible.
- Minimum bottle cycle, with sensors responding immediately: ADVANCE 1 + FILL 1 + SEAL `SEAL_CYCLES` + RELEASE 1 + COUNT 1 + CHECK 1 = `SEAL_CYCLES`+5 cycles.
- Fill timeout: `ALARM` rises `FILL_TIMEOUT`+1 cycles after FILL entry if `FULL` never asserts.
- `FULL` in the same cycle the timer reaches its limit: `FULL` wins, the FSM goes to SEAL.

## Configuration
- `FILL_TIMEOUT_EN` defined: fill timer, FAULT state and `ALARM` are present as described.
- Not defined: no timer is built and FILL waits for `FULL` indefinitely. The FAULT state does not exist and `ALARM` is tied to 0. `FILL_TIMEOUT` is unused.

## Test plan
- Reset, then 12 bottles with `SEAL_CYCLES`=4 and instant sensors:
  - each bottle takes 9 cycles;
  - `BOTTLES` reads 1..11 then 0;
  - exactly one `DOZEN_PULSE`, in the 12th COUNT.
- 120 bottles with a real dozen counter attached and `DOZEN_LIMIT`=10:
  - `BATCH_DONE`=1 and `DOZEN_COUNT`=10;
  - `START` → one CLEAR pulse, `DOZEN_COUNT`=0, line restarts.
- `FILL_TIMEOUT_EN` with `FILL_TIMEOUT`=8 and `FULL` held 0:
  - `ALARM` rises 9 cycles after FILL entry and `VALVE`=0;
  - `START` → IDLE with `BOTTLES` unchanged.
- `STOP` pulse during SEAL at `BOTTLES`=5: bottle completes, `BOTTLES`=6, FSM reaches IDLE without re-entering ADVANCE.
- `RESET` asserted mid-FILL at `BOTTLES`=7: next cycle `VALVE`=0, `BOTTLES`=0, state IDLE.
- `FULL` and timeout limit in the same cycle: FSM enters SEAL and `ALARM` stays 0.
